// File: rtl/picosoc_ledpwm.sv
// picosoc_ledpwm: memory-mapped LED/GPIO output block for the PicoSoC iomem bus.
// Each of NUM_CH channels is either a static level (OUT) or a PWM output whose
// duty cycle comes from a double-buffered DUTY register. One prescaler and one
// PWM counter are shared by all channels. Duty values reach the comparators only
// at a PWM period boundary, so a channel never emits a truncated or stretched pulse.
module picosoc_ledpwm #(
   parameter int          NUM_CH        = 8,
   parameter int          PWM_BITS      = 8,
   parameter int          PRESCALE_BITS = 16,
   parameter logic [31:0] BASE_ADDR     = 32'h0300_0000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              iomem_valid,
   output logic              iomem_ready,
   input  logic [3:0]        iomem_wstrb,
   input  logic [31:0]       iomem_addr,
   input  logic [31:0]       iomem_wdata,
   output logic [31:0]       iomem_rdata,
   output logic [NUM_CH-1:0] leds
);

   // Word offsets inside the 256-byte window (byte offset >> 2)
   localparam logic [5:0] OFF_OUT      = 6'd0;
   localparam logic [5:0] OFF_MODE     = 6'd1;
   localparam logic [5:0] OFF_PRESCALE = 6'd2;
   localparam logic [5:0] OFF_STATUS   = 6'd3;
   localparam logic [5:0] OFF_DUTY0    = 6'd4;

   // Software-visible registers
   logic [NUM_CH-1:0]        out_q;
   logic [NUM_CH-1:0]        mode_q;
   logic [PRESCALE_BITS-1:0] prescale_q;
   logic [PWM_BITS-1:0]      duty_sh  [NUM_CH];
   logic                     wrap_flag;

   // Timebase and per-channel compare state
   logic [PRESCALE_BITS-1:0] presc_cnt;
   logic [PWM_BITS-1:0]      pwm_cnt;
   logic [PWM_BITS-1:0]      duty_act [NUM_CH];
   logic                     tick;
   logic                     wrap;

   // Bus decode
   logic        hit;
   logic        req;
   logic        wr_en;
   logic        rd_en;
   logic        status_rd;
   logic [5:0]  word;
   logic [5:0]  duty_idx;
   logic        duty_sel;
   logic [PWM_BITS-1:0] duty_cur;
   logic [31:0] rd_mux;
   logic [31:0] out_wr;
   logic [31:0] mode_wr;
   logic [31:0] presc_wr;
   logic [31:0] duty_wr;
   logic        unused_bits;

   // Overlay the strobed bytes of the write data onto the current register value
   function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = cur;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

   // A request is accepted only while ready is low, so each access acks exactly once
   assign hit       = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
   assign req       = hit && !iomem_ready;
   assign wr_en     = req && (iomem_wstrb != 4'b0000);
   assign rd_en     = req && (iomem_wstrb == 4'b0000);
   assign word      = iomem_addr[7:2];
   assign status_rd = rd_en && (word == OFF_STATUS);
   assign duty_idx  = word - OFF_DUTY0;
   assign duty_sel  = (word >= OFF_DUTY0) && (duty_idx < 6'(NUM_CH));

   // Prescaler reaching PRESCALE advances the PWM counter; the all-ones step ends a period
   assign tick = (presc_cnt == prescale_q);
   assign wrap = tick && (pwm_cnt == '1);

   // Address bits [1:0] and merged bits above each register's width are dropped on purpose
   assign unused_bits = ^{iomem_addr[1:0], out_wr, mode_wr, presc_wr, duty_wr};

   // Shadow duty of the addressed channel, shared by readback and byte merging
   always_comb begin
      duty_cur = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (duty_idx == 6'(i)) duty_cur = duty_sh[i];
      end
   end

   // Byte-merged write values and read-data mux
   always_comb begin
      out_wr   = merge_bytes(32'(out_q), iomem_wdata, iomem_wstrb);
      mode_wr  = merge_bytes(32'(mode_q), iomem_wdata, iomem_wstrb);
      presc_wr = merge_bytes(32'(prescale_q), iomem_wdata, iomem_wstrb);
      duty_wr  = merge_bytes(32'(duty_cur), iomem_wdata, iomem_wstrb);
      rd_mux   = '0;
      case (word)
         OFF_OUT:      rd_mux = 32'(out_q);
         OFF_MODE:     rd_mux = 32'(mode_q);
         OFF_PRESCALE: rd_mux = 32'(prescale_q);
         OFF_STATUS: begin
            rd_mux     = 32'(pwm_cnt);
            rd_mux[31] = wrap_flag;
         end
         default: begin
            if (duty_sel) rd_mux = 32'(duty_cur);
         end
      endcase
   end

   // Bus handshake, register writes and the sticky wrap flag
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
         out_q       <= '0;
         mode_q      <= '0;
         prescale_q  <= '0;
         wrap_flag   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= '0;
      end else begin
         iomem_ready <= req;
         iomem_rdata <= rd_en ? rd_mux : '0;
         if (wr_en) begin
            case (word)
               OFF_OUT:      out_q      <= out_wr[NUM_CH-1:0];
               OFF_MODE:     mode_q     <= mode_wr[NUM_CH-1:0];
               OFF_PRESCALE: prescale_q <= presc_wr[PRESCALE_BITS-1:0];
               default:      ;
            endcase
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && duty_sel && (duty_idx == 6'(i))) duty_sh[i] <= duty_wr[PWM_BITS-1:0];
         end
         // A wrap coinciding with a STATUS read keeps the flag set
         if (wrap) wrap_flag <= 1'b1;
         else if (status_rd) wrap_flag <= 1'b0;
      end
   end

   // Shared timebase: the prescaler free-runs past a lowered PRESCALE until it wraps around
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         presc_cnt <= '0;
         pwm_cnt   <= '0;
      end else begin
         if (tick) begin
            presc_cnt <= '0;
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
         end else begin
            presc_cnt <= presc_cnt + PRESCALE_BITS'(1);
         end
      end
   end

   // Active duty follows the shadow continuously in static mode and only at wrap in PWM mode
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (wrap || !mode_q[i]) duty_act[i] <= duty_sh[i];
         end
      end
   end

   // Registered channel outputs: PWM compare or static level
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         leds <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            leds[i] <= mode_q[i] ? (pwm_cnt < duty_act[i]) : out_q[i];
         end
      end
   end

endmodule

// File: tb/tb_picosoc_ledpwm.sv
// tb_picosoc_ledpwm: self-checking bench for picosoc_ledpwm (8 channels, 8-bit PWM,
// 2-bit prescaler so a lowered PRESCALE visibly runs through all-ones and wraps).
module tb_picosoc_ledpwm;

   localparam int          NUM_CH        = 8;
   localparam int          PWM_BITS      = 8;
   localparam int          PRESCALE_BITS = 2;
   localparam logic [31:0] BASE          = 32'h0300_0000;

   logic              clk = 1'b0;
   logic              resetn;
   logic              iomem_valid;
   logic              iomem_ready;
   logic [3:0]        iomem_wstrb;
   logic [31:0]       iomem_addr;
   logic [31:0]       iomem_wdata;
   logic [31:0]       iomem_rdata;
   logic [NUM_CH-1:0] leds;

   picosoc_ledpwm #(
      .NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .PRESCALE_BITS(PRESCALE_BITS), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
      .iomem_rdata(iomem_rdata), .leds(leds)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int last_lat = 0;

   typedef struct packed {
      logic        chk;
      logic [31:0] exp;
      logic [31:0] mask;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic [7:0]  off;
      logic [3:0]  strb;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic [7:0]  exp_leds;
   } vec_t;
   vec_t vecs[13];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   // One bus access; the expectation is queued at drive time and retired at the ack
   task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                           input logic chk, input logic [31:0] exp, input logic [31:0] mask,
                           input string nm, input bit imm);
      sb_t e;
      int  n;
      bit  acked;
      e.chk = chk; e.exp = exp; e.mask = mask;
      sb_q.push_back(e);
      if (!imm) begin
         @(posedge clk); #1;
      end
      iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = wd;
      acked = 1'b0; n = 0;
      while (!acked && n < 8) begin
         @(posedge clk); #1;
         n++;
         if (iomem_ready) acked = 1'b1;
      end
      last_lat = n;
      e = sb_q.pop_front();
      if (!acked) begin
         checks++; errors++;
         $display("FAIL %s: no ack within %0d cycles, required an ack", nm, n);
      end else if (e.chk) begin
         check(nm, iomem_rdata & e.mask, e.exp & e.mask);
      end
      iomem_valid = 1'b0; iomem_wstrb = 4'b0000;
   endtask

   task automatic wr(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd, input string nm);
      bus_xfer(BASE + {24'h0, off}, strb, wd, 1'b0, 32'h0, 32'h0, nm, 1'b0);
   endtask

   task automatic rd(input logic [7:0] off, input logic [31:0] exp, input logic [31:0] mask, input string nm);
      bus_xfer(BASE + {24'h0, off}, 4'b0000, 32'h0, 1'b1, exp, mask, nm, 1'b0);
   endtask

   task automatic wait_level(input logic lvl, input int budget, input string nm, output int at);
      int n;
      n = 0;
      while (leds[0] !== lvl && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (leds[0] !== lvl) begin
         checks++; errors++;
         $display("FAIL %s: leds[0] never reached %0b within %0d cycles", nm, lvl, budget);
      end
      at = cyc;
   endtask

   task automatic wait_change(input logic [7:0] from, input int budget, input string nm,
                              output int at, output logic [7:0] val);
      int n;
      n = 0;
      while (leds === from && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (leds === from) begin
         checks++; errors++;
         $display("FAIL %s: leds stuck at 0x%02h for %0d cycles", nm, from, budget);
      end
      at = cyc; val = leds;
   endtask

   int          r0, f0, r1, f1, r2, f2, r3, f3, c0, cs, c2, at, n;
   logic [7:0]  prev, val;
   bit          found;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{8'h00, 4'b0001, 32'h0000_00A5, 32'h0000_00A5, 8'hA5};
      vecs[1]  = '{8'h00, 4'b0010, 32'hFFFF_FFFF, 32'h0000_00A5, 8'hA5};
      vecs[2]  = '{8'h03, 4'b0001, 32'h0000_003C, 32'h0000_003C, 8'h3C};
      vecs[3]  = '{8'h00, 4'b1111, 32'hFFFF_FF5A, 32'h0000_005A, 8'h5A};
      vecs[4]  = '{8'h04, 4'b1110, 32'hFFFF_FFFF, 32'h0000_0000, 8'h5A};
      vecs[5]  = '{8'h08, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0003, 8'h5A};
      vecs[6]  = '{8'h08, 4'b0001, 32'h0000_0000, 32'h0000_0000, 8'h5A};
      vecs[7]  = '{8'h10, 4'b0001, 32'h0000_0040, 32'h0000_0040, 8'h5A};
      vecs[8]  = '{8'h2C, 4'b0011, 32'h0000_1234, 32'h0000_0034, 8'h5A};
      vecs[9]  = '{8'h30, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000, 8'h5A};
      vecs[10] = '{8'h80, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000, 8'h5A};
      vecs[11] = '{8'hFC, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000, 8'h5A};
      vecs[12] = '{8'h01, 4'b0001, 32'h0000_00A5, 32'h0000_00A5, 8'hA5};

      resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'b0000;
      iomem_addr = 32'h0; iomem_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", 32'(iomem_ready), 32'h0);
      check("reset_rdata", iomem_rdata, 32'h0);
      check("reset_leds", 32'(leds), 32'h0);
      resetn = 1'b1;
      rd(8'h00, 32'h0, 32'hFFFF_FFFF, "init_out");
      rd(8'h0C, 32'h0, 32'h8000_0000, "init_status_flag");

      // Register table: write, observe leds one cycle later, read back
      for (int i = 0; i < 13; i++) begin
         wr(vecs[i].off, vecs[i].strb, vecs[i].wd, "tbl_wr");
         if (i == 0) begin
            check("ack_latency", 32'(last_lat), 32'd1);
            check("leds_before_update", 32'(leds), 32'h0);
         end
         @(posedge clk); #1;
         check($sformatf("tbl_leds_%0d", i), 32'(leds), 32'(vecs[i].exp_leds));
         rd(vecs[i].off, vecs[i].exp_rd, 32'hFFFF_FFFF, $sformatf("tbl_rd_%0d", i));
      end

      // Access just outside the window must never be acknowledged
      @(posedge clk); #1;
      iomem_valid = 1'b1; iomem_addr = BASE + 32'h100; iomem_wstrb = 4'b0000;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (iomem_ready) n++;
      end
      iomem_valid = 1'b0;
      check("miss_no_ack", 32'(n), 32'h0);

      // PWM: duty 64 of 256 with PRESCALE=0
      wr(8'h04, 4'b0001, 32'h01, "mode_pwm0");
      wait_level(1'b0, 600, "pwm_sync_low", at);
      wait_level(1'b1, 600, "pwm_rise0", r0);
      wait_level(1'b0, 600, "pwm_fall0", f0);
      wait_level(1'b1, 600, "pwm_rise1", r1);
      wait_level(1'b0, 600, "pwm_fall1", f1);
      check("pwm_high_64", 32'(f0 - r0), 32'd64);
      check("pwm_low_192", 32'(r1 - f0), 32'd192);
      check("pwm_period_256", 32'(r1 - r0), 32'd256);
      check("pwm_high_64_again", 32'(f1 - r1), 32'd64);

      // Duty change mid-period takes effect only after the next wrap
      wait_level(1'b1, 600, "dbuf_rise", r2);
      repeat (10) @(posedge clk);
      wr(8'h10, 4'b0001, 32'd192, "duty0_192");
      wait_level(1'b0, 600, "dbuf_fall", f2);
      wait_level(1'b1, 600, "dbuf_rise2", r3);
      wait_level(1'b0, 600, "dbuf_fall2", f3);
      check("dbuf_current_64", 32'(f2 - r2), 32'd64);
      check("dbuf_low_192", 32'(r3 - f2), 32'd192);
      check("dbuf_next_192", 32'(f3 - r3), 32'd192);
      rd(8'h0C, 32'h8000_0000, 32'h8000_0000, "status_wrap_set");
      rd(8'h0C, 32'h0000_0000, 32'h8000_0000, "status_wrap_cleared");

      // Prescaler: thermometer duties make leds show pwm_cnt 0..7 directly
      wr(8'h04, 4'b0001, 32'h00, "mode_static");
      for (int i = 0; i < NUM_CH; i++) wr(8'h10 + 8'(4 * i), 4'b0001, 32'(i + 1), "duty_thermo");
      wr(8'h08, 4'b0001, 32'h3, "prescale_3");
      wr(8'h04, 4'b0001, 32'hFF, "mode_all_pwm");
      prev = leds; found = 1'b0; n = 0;
      while (!found && n < 3000) begin
         @(posedge clk); #1;
         n++;
         if (leds == 8'hFF && prev != 8'hFF) found = 1'b1;
         prev = leds;
      end
      check("presc_find_cnt0", 32'(found), 32'h1);
      c0 = cyc;
      wait_change(8'hFF, 20, "presc_step1", cs, val);
      check("presc_cnt1_val", 32'(val), 32'hFE);
      check("presc_step_4", 32'(cs - c0), 32'd4);
      bus_xfer(BASE + 32'h08, 4'b0001, 32'h1, 1'b0, 32'h0, 32'h0, "prescale_1", 1'b1);
      wait_change(8'hFE, 20, "presc_step2", c2, val);
      check("presc_cnt2_val", 32'(val), 32'hFC);
      check("presc_runout_6", 32'(c2 - cs), 32'd6);
      wait_change(8'hFC, 20, "presc_step3", at, val);
      check("presc_cnt3_val", 32'(val), 32'hF8);
      check("presc_step_2", 32'(at - c2), 32'd2);

      // Asynchronous reset in the middle of an acknowledged access
      wr(8'h04, 4'b0001, 32'h00, "mode_static2");
      wr(8'h00, 4'b0001, 32'hA5, "out_a5");
      @(posedge clk); #1;
      check("leds_before_reset", 32'(leds), 32'hA5);
      @(posedge clk); #1;
      iomem_valid = 1'b1; iomem_addr = BASE; iomem_wstrb = 4'b0000;
      @(posedge clk); #1;
      check("ack_before_reset", 32'(iomem_ready), 32'h1);
      #1 resetn = 1'b0;
      #1;
      check("async_reset_ready", 32'(iomem_ready), 32'h0);
      check("async_reset_leds", 32'(leds), 32'h0);
      check("async_reset_rdata", iomem_rdata, 32'h0);
      iomem_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      rd(8'h00, 32'h0, 32'hFFFF_FFFF, "post_out");
      rd(8'h04, 32'h0, 32'hFFFF_FFFF, "post_mode");
      rd(8'h08, 32'h0, 32'hFFFF_FFFF, "post_prescale");
      rd(8'h10, 32'h0, 32'hFFFF_FFFF, "post_duty0");
      rd(8'h2C, 32'h0, 32'hFFFF_FFFF, "post_duty7");
      rd(8'h0C, 32'h0, 32'h8000_0000, "post_status_flag");
      check("post_leds", 32'(leds), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
